// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_pkg
// Description : Shared types and constants for the posted-write store buffer.
//               Holds the default address/data widths, the buffered entry
//               record and the polarity of the memory write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    localparam int SB_AW = 16;
    localparam int SB_DW = 16;

    // Level that makes the data memory perform a write (strobe is active-low).
    localparam logic MEM_WR_ACTIVE = 1'b0;

    // One buffered store. Field widths follow SB_AW/SB_DW, so the buffer's
    // AW/DW parameters are expected to keep these defaults.
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage : store_buffer_pkg
`default_nettype wire

// File: rtl/store_buf_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : store_buf_fwd_match
// Description : Combinational youngest-match selector for load forwarding.
//               Scans the buffer in age order starting at the head, so a later
//               (younger) match overrides an earlier one.
// Ports       : i_entries  buffered {addr,data} records
//               i_valid    per-slot occupancy
//               i_head     oldest slot index
//               i_ld_addr  load address to look up
//               o_hit      some valid entry matches i_ld_addr
//               o_data     data of the youngest matching entry (0 when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module store_buf_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  sb_entry_t                  i_entries [DEPTH],
    input  logic [DEPTH-1:0]           i_valid,
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [AW-1:0]              i_ld_addr,
    output logic                       o_hit,
    output logic [DW-1:0]              o_data
);

    localparam int c_PW = $clog2(DEPTH);

    logic [c_PW-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        // Oldest to youngest; the last hit seen is the youngest one.
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + c_PW'(i);
            if (i_valid[w_idx] && (i_entries[w_idx].addr == i_ld_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule : store_buf_fwd_match
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write buffer between the CPU memory stage and a 16-bit
//               word-addressed data memory. Stores are accepted in one cycle,
//               drained in order (one per granted cycle) and loads see the
//               youngest pending store to their address.
// Options     : STORE_BUF_COALESCE_EN - a store hitting the youngest entry's
//               address overwrites that entry instead of allocating.
// Ports       : clk, rst (async, active-high)
//               st_valid/st_ready/st_addr/st_data   store request channel
//               ld_addr -> ld_data/ld_fwd            load lookup (combinational)
//               drain_en                             memory write grant
//               mem_write_add/mem_in/mem_write       memory write port (low-active)
//               mem_read_add/mem_out                 memory read port
//               count/empty/full                     occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic [AW-1:0]            ld_addr,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_fwd,
    input  logic                     drain_en,
    output logic [AW-1:0]            mem_write_add,
    output logic [DW-1:0]            mem_in,
    output logic                     mem_write,
    output logic [AW-1:0]            mem_read_add,
    input  logic [DW-1:0]            mem_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int              c_PW        = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_DEPTH_CNT = DEPTH[c_PW:0];
    localparam logic [c_PW:0]   c_CNT_ONE   = (c_PW+1)'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);

    logic [c_PW-1:0]  r_head;
    logic [c_PW-1:0]  r_tail;
    logic [c_PW:0]    r_count;
    sb_entry_t        r_mem [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_drain;
    logic             w_alloc;
    logic             w_hit;
    logic [DEPTH-1:0] w_valid;
    logic [DW-1:0]    w_fwd_data;

    // ------------------------------------------------------------------
    // Status, handshake and drain decision (all from registered state)
    // ------------------------------------------------------------------
    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_enq   = st_valid && !w_full;
    assign w_drain = !w_empty && drain_en;

    assign st_ready = !w_full;
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;

`ifdef STORE_BUF_COALESCE_EN
    logic [c_PW-1:0] w_youngest;
    logic            w_coalesce;

    // The youngest entry is the head when count==1; if it is leaving this
    // cycle the new store must get its own slot rather than be lost.
    assign w_youngest = r_tail - c_PTR_ONE;
    assign w_coalesce = w_enq && !w_empty
                        && (r_mem[w_youngest].addr == st_addr)
                        && !(w_drain && (r_count == c_CNT_ONE));
    assign w_alloc    = w_enq && !w_coalesce;
`else
    assign w_alloc    = w_enq;
`endif

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_drain) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_alloc, w_drain})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_mem[r_tail].addr <= st_addr;
            r_mem[r_tail].data <= st_data;
        end
`ifdef STORE_BUF_COALESCE_EN
        if (w_coalesce) begin
            r_mem[w_youngest].data <= st_data;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Memory write port: always presents the head entry
    // ------------------------------------------------------------------
    assign mem_write_add = r_mem[r_head].addr;
    assign mem_in        = r_mem[r_head].data;
    assign mem_write     = w_drain ? MEM_WR_ACTIVE : ~MEM_WR_ACTIVE;

    // ------------------------------------------------------------------
    // Load forwarding
    // ------------------------------------------------------------------
    // A slot is live when its distance from head is below the count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [c_PW-1:0] w_rel;
            assign w_rel       = c_PW'(gi) - r_head;
            assign w_valid[gi] = ({1'b0, w_rel} < r_count);
        end
    endgenerate

    store_buf_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd_match (
        .i_entries (r_mem),
        .i_valid   (w_valid),
        .i_head    (r_head),
        .i_ld_addr (ld_addr),
        .o_hit     (w_hit),
        .o_data    (w_fwd_data)
    );

    assign mem_read_add = ld_addr;
    assign ld_fwd       = w_hit;
    assign ld_data      = w_hit ? w_fwd_data : mem_out;

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer (DEPTH=4). A vector table
//               covers reset/idle, fill, overflow, forwarding and in-order
//               drain; short hand-written sequences cover duplicate-address
//               forwarding (with or without STORE_BUF_COALESCE_EN), concurrent
//               enqueue/drain with pointer wrap, asynchronous reset with
//               pending entries, and same-cycle store/load visibility.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_fwd;
    logic        drain_en;
    logic [15:0] mem_write_add;
    logic [15:0] mem_in;
    logic        mem_write;
    logic [15:0] mem_read_add;
    logic [15:0] mem_out;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_fwd        (ld_fwd),
        .drain_en      (drain_en),
        .mem_write_add (mem_write_add),
        .mem_in        (mem_in),
        .mem_write     (mem_write),
        .mem_read_add  (mem_read_add),
        .mem_out       (mem_out),
        .count         (count),
        .empty         (empty),
        .full          (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [15:0] sa;
        logic [15:0] sd;
        logic [15:0] la;
        logic [15:0] mo;
        logic        de;
        logic [2:0]  cnt;
        logic        emp;
        logic        ful;
        logic        rdy;
        logic        mw;
        logic        chkw;
        logic [15:0] wa;
        logic [15:0] wd;
        logic        fwd;
        logic [15:0] ld;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                         input logic [15:0] la, input logic [15:0] mo, input logic de);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_addr  = la;
        mem_out  = mo;
        drain_en = de;
    endtask

    logic [15:0] q [$];
    int          nw;
    logic [15:0] last_wd;
    int          exp_dup_cnt;

    initial begin
`ifdef STORE_BUF_COALESCE_EN
        exp_dup_cnt = 1;
`else
        exp_dup_cnt = 2;
`endif
        //            sv    sa      sd        la        mo        de    cnt   emp   ful   rdy   mw    chkw  wa      wd        fwd   ld
        vecs[0]  = '{1'b0, 16'h0, 16'h0,    16'h0010, 16'hBEEF, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0,    1'b0, 16'hBEEF};
        vecs[1]  = '{1'b1, 16'h1, 16'h1111, 16'h0001, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 16'h2, 16'h2222, 16'h0001, 16'h0000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0,    1'b1, 16'h1111};
        vecs[3]  = '{1'b1, 16'h3, 16'h3333, 16'h0002, 16'h0000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0,    1'b1, 16'h2222};
        vecs[4]  = '{1'b1, 16'h4, 16'h4444, 16'h0003, 16'h0000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0,    1'b1, 16'h3333};
        vecs[5]  = '{1'b1, 16'h5, 16'h5555, 16'h0004, 16'h0000, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0,    1'b1, 16'h4444};
        vecs[6]  = '{1'b0, 16'h0, 16'h0,    16'h0005, 16'h1234, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1, 16'h1111, 1'b0, 16'h1234};
        vecs[7]  = '{1'b0, 16'h0, 16'h0,    16'h0001, 16'h0000, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1, 16'h1111, 1'b1, 16'h1111};
        vecs[8]  = '{1'b0, 16'h0, 16'h0,    16'h0001, 16'h00AA, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2, 16'h2222, 1'b0, 16'h00AA};
        vecs[9]  = '{1'b0, 16'h0, 16'h0,    16'h0002, 16'h00AA, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3, 16'h3333, 1'b0, 16'h00AA};
        vecs[10] = '{1'b0, 16'h0, 16'h0,    16'h0004, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h4, 16'h4444, 1'b1, 16'h4444};
        vecs[11] = '{1'b0, 16'h0, 16'h0,    16'h0004, 16'h0F0F, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0F0F};

        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].la, vecs[i].mo, vecs[i].de);
            #1;
            check($sformatf("v%0d_count", i),     32'(count),     32'(vecs[i].cnt));
            check($sformatf("v%0d_empty", i),     32'(empty),     32'(vecs[i].emp));
            check($sformatf("v%0d_full", i),      32'(full),      32'(vecs[i].ful));
            check($sformatf("v%0d_st_ready", i),  32'(st_ready),  32'(vecs[i].rdy));
            check($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].mw));
            if (vecs[i].chkw) begin
                check($sformatf("v%0d_wr_addr", i), 32'(mem_write_add), 32'(vecs[i].wa));
                check($sformatf("v%0d_wr_data", i), 32'(mem_in),        32'(vecs[i].wd));
            end
            check($sformatf("v%0d_ld_fwd", i),   32'(ld_fwd),       32'(vecs[i].fwd));
            check($sformatf("v%0d_ld_data", i),  32'(ld_data),      32'(vecs[i].ld));
            check($sformatf("v%0d_rd_addr", i),  32'(mem_read_add), 32'(vecs[i].la));
        end

        // ---------------- duplicate address: youngest wins ----------------
        @(negedge clk);
        drive(1'b1, 16'h0020, 16'hAAAA, 16'h0020, 16'h0000, 1'b0);
        #1;
        check("dup_first_fwd", 32'(ld_fwd), 32'd0);
        @(negedge clk);
        drive(1'b1, 16'h0020, 16'hBBBB, 16'h0020, 16'h0000, 1'b0);
        #1;
        check("dup_mid_data", 32'(ld_data), 32'hAAAA);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 16'h0020, 16'h0000, 1'b0);
        #1;
        check("dup_fwd", 32'(ld_fwd), 32'd1);
        check("dup_data", 32'(ld_data), 32'hBBBB);
        check("dup_count", 32'(count), 32'(exp_dup_cnt));
        nw = 0;
        last_wd = 16'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
            #1;
            if (empty) break;
            if (mem_write == 1'b0) begin
                nw++;
                last_wd = mem_in;
            end
        end
        check("dup_writes", 32'(nw), 32'(exp_dup_cnt));
        check("dup_last_wd", 32'(last_wd), 32'hBBBB);
        check("dup_drained", 32'(empty), 32'd1);

        // ---------------- concurrent enqueue and drain, pointer wrap ----------------
        q.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 16'h0100 + 16'(k), (16'h0100 + 16'(k)) ^ 16'h5A5A, 16'h0, 16'h0, 1'b0);
            q.push_back(16'h0100 + 16'(k));
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(1'b1, 16'h0102 + 16'(k), (16'h0102 + 16'(k)) ^ 16'h5A5A, 16'h0, 16'h0, 1'b1);
            #1;
            check($sformatf("cc%0d_count", k), 32'(count), 32'd2);
            check($sformatf("cc%0d_mem_write", k), 32'(mem_write), 32'd0);
            check($sformatf("cc%0d_wr_addr", k), 32'(mem_write_add), 32'(q[0]));
            check($sformatf("cc%0d_wr_data", k), 32'(mem_in), 32'(q[0] ^ 16'h5A5A));
            q.push_back(16'h0102 + 16'(k));
            void'(q.pop_front());
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
            #1;
            check($sformatf("cct%0d_wr_addr", k), 32'(mem_write_add), 32'(q[0]));
            void'(q.pop_front());
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        #1;
        check("cc_empty", 32'(empty), 32'd1);

        // ---------------- asynchronous reset with pending stores ----------------
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 16'h0040 + 16'(k), 16'hC000 + 16'(k), 16'h0, 16'h0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 16'h0040, 16'h7777, 1'b1);
        #1;
        check("ar_pre_count", 32'(count), 32'd3);
        check("ar_pre_mem_write", 32'(mem_write), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_mem_write", 32'(mem_write), 32'd1);
        check("ar_st_ready", 32'(st_ready), 32'd1);
        check("ar_ld_fwd", 32'(ld_fwd), 32'd0);
        check("ar_ld_data", 32'(ld_data), 32'h7777);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("ar_post%0d_mem_write", k), 32'(mem_write), 32'd1);
        end

        // ---------------- same-cycle store/load visibility ----------------
        @(negedge clk);
        drive(1'b1, 16'h0030, 16'h5555, 16'h0030, 16'h0000, 1'b0);
        #1;
        check("vis_same_fwd", 32'(ld_fwd), 32'd0);
        check("vis_same_data", 32'(ld_data), 32'h0000);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 16'h0030, 16'h0000, 1'b0);
        #1;
        check("vis_next_fwd", 32'(ld_fwd), 32'd1);
        check("vis_next_data", 32'(ld_data), 32'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_store_buffer
`default_nettype wire
